shift_unit_seq: RTL and testbench

- Parametrised, multi-cycle barrel-shift unit for the multi-cycle MIPS datapath. Successor to the 3:1 shift-amount select mux.
- Integrates the amount-source select (sign-extended field, constant, IR[10:6] shamt, register operand) with an iterative shifter.
- Supports five shift/rotate modes.
- Uses a start/busy/done handshake with the control unit, which holds its FSM in a wait state until done.

---
 rtl/shift_unit_seq_pkg.sv | 26 ++
 rtl/shift_unit_seq_if.sv | 29 ++
 rtl/shift_unit_seq_amt_sel.sv | 31 +++
 rtl/shift_unit_seq.sv | 124 ++++++++++++
 tb/tb_shift_unit_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_unit_seq_pkg.sv
// Shared encodings for the multi-cycle shift unit.
// Op and amount-select codes, FSM states and an op-legality helper.
package shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [1:0] AMT_SE    = 2'b00;
    localparam logic [1:0] AMT_CONST = 2'b01;
    localparam logic [1:0] AMT_SHAMT = 2'b10;
    localparam logic [1:0] AMT_REG   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [2:0] o);
        return (o <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Start/busy/done bundle between the control unit and the shift unit.
// The control unit is the master; the shift unit is the slave.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             start;
    logic [2:0]       op;
    logic [1:0]       amt_sel;
    logic [AMT_W-1:0] amt_se;
    logic [AMT_W-1:0] amt_shamt;
    logic [WIDTH-1:0] amt_reg;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, amt_sel, amt_se, amt_shamt, amt_reg, din,
        input  ready, busy, done, illegal, result
    );

    modport slave (
        input  start, op, amt_sel, amt_se, amt_shamt, amt_reg, din,
        output ready, busy, done, illegal, result
    );
endinterface

// File: rtl/shift_unit_seq_amt_sel.sv
// Combinational 4:1 shift-amount select; the result is taken modulo WIDTH.
// Shared with the control-unit datapath.
module shift_amt_sel
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = $clog2(WIDTH),
    parameter int CONST_AMT = 16
) (
    input  logic [1:0]       amt_sel,
    input  logic [AMT_W-1:0] amt_se,
    input  logic [AMT_W-1:0] amt_shamt,
    input  logic [WIDTH-1:0] amt_reg,
    output logic [AMT_W-1:0] amt
);
    localparam logic [AMT_W-1:0] CONST_A = AMT_W'(CONST_AMT);

    logic unused_hi;
    assign unused_hi = ^amt_reg[WIDTH-1:AMT_W];

    always_comb begin
        amt = '0;
        unique case (amt_sel)
            AMT_SE:    amt = amt_se;
            AMT_CONST: amt = CONST_A;
            AMT_SHAMT: amt = amt_shamt;
            AMT_REG:   amt = amt_reg[AMT_W-1:0];
            default:   amt = '0;
        endcase
    end
endmodule

// File: rtl/shift_unit_seq.sv
// Iterative barrel shifter: up to STEP bits per cycle, five shift/rotate
// modes, start/busy/done handshake with back-to-back accept from DONE.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = $clog2(WIDTH),
    parameter int STEP      = 1,
    parameter int CONST_AMT = 16
) (
    input  logic           clk,
    input  logic           reset,
    shift_unit_seq_if.slave bus
);
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_e           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op_r, op_nx;
    logic             ill_r, ill_nx;
    logic [AMT_W-1:0] amt;
    logic [AMT_W-1:0] step;
    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             legal;

    shift_amt_sel #(
        .WIDTH     (WIDTH),
        .AMT_W     (AMT_W),
        .CONST_AMT (CONST_AMT)
    ) u_amt (
        .amt_sel   (bus.amt_sel),
        .amt_se    (bus.amt_se),
        .amt_shamt (bus.amt_shamt),
        .amt_reg   (bus.amt_reg),
        .amt       (amt)
    );

    // Rotations shift a doubled word and keep the half that wraps in.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic [AMT_W-1:0] s
    );
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   r;
        dbl = {v, v};
        r   = v;
        unique case (o)
            OP_SLL: r = v << s;
            OP_SRL: r = v >> s;
            OP_SRA: r = WIDTH'($signed(v) >>> s);
            OP_ROL: begin
                dbl = dbl << s;
                r   = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = dbl >> s;
                r   = dbl[WIDTH-1:0];
            end
            default: r = v;
        endcase
        return r;
    endfunction

    assign accept  = bus.start && (state != S_SHIFT);
    assign legal   = op_legal(bus.op);
    assign step    = (cnt < STEP_A) ? cnt : STEP_A;
    assign shifted = step_shift(op_r, work, step);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= '0;
            op_r  <= OP_SLL;
            ill_r <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            cnt   <= cnt_nx;
            op_r  <= op_nx;
            ill_r <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        op_nx    = op_r;
        ill_nx   = ill_r;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    work_nx = bus.din;
                    op_nx   = bus.op;
                    cnt_nx  = amt;
                    ill_nx  = !legal;
                    if (amt == '0 || !legal)
                        state_nx = S_DONE;
                    else
                        state_nx = S_SHIFT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_nx = shifted;
                cnt_nx  = cnt - step;
                if (cnt == step)
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.ready   = (state != S_SHIFT);
    assign bus.busy    = (state == S_SHIFT);
    assign bus.done    = (state == S_DONE);
    assign bus.illegal = (state == S_DONE) && ill_r;
    assign bus.result  = work;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: STEP=1 and STEP=4 instances,
// vector table plus reset-abort and back-to-back sequences.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shift_unit_seq_if #(.WIDTH(32)) i1 ();
    shift_unit_seq_if #(.WIDTH(32)) i4 ();

    shift_unit_seq #(.WIDTH(32), .STEP(1), .CONST_AMT(16)) u1 (
        .clk   (clk),
        .reset (rst),
        .bus   (i1)
    );

    shift_unit_seq #(.WIDTH(32), .STEP(4), .CONST_AMT(16)) u4 (
        .clk   (clk),
        .reset (rst),
        .bus   (i4)
    );

    typedef struct {
        bit          s4;
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [4:0]  se;
        logic [4:0]  shamt;
        logic [31:0] rg;
        logic [31:0] din;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s4, input logic [2:0] op,
                         input logic [1:0] sel, input logic [4:0] se,
                         input logic [4:0] shamt, input logic [31:0] rg,
                         input logic [31:0] din, input logic st);
        if (s4) begin
            i4.start = st; i4.op = op; i4.amt_sel = sel;
            i4.amt_se = se; i4.amt_shamt = shamt;
            i4.amt_reg = rg; i4.din = din;
        end else begin
            i1.start = st; i1.op = op; i1.amt_sel = sel;
            i1.amt_se = se; i1.amt_shamt = shamt;
            i1.amt_reg = rg; i1.din = din;
        end
    endtask

    function automatic logic done_of(input bit s4);
        return s4 ? i4.done : i1.done;
    endfunction

    function automatic logic busy_of(input bit s4);
        return s4 ? i4.busy : i1.busy;
    endfunction

    function automatic logic ill_of(input bit s4);
        return s4 ? i4.illegal : i1.illegal;
    endfunction

    function automatic logic [31:0] res_of(input bit s4);
        return s4 ? i4.result : i1.result;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int bsy;
        logic [31:0] held;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v.s4, v.op, v.sel, v.se, v.shamt, v.rg, v.din, 1'b1);
        @(posedge clk);
        #1;
        drive(v.s4, v.op, v.sel, v.se, v.shamt, v.rg, v.din, 1'b0);
        lat = 1;
        bsy = 0;
        while (!done_of(v.s4) && lat < 100) begin
            if (busy_of(v.s4)) bsy++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_result"}, res_of(v.s4), v.res);
        check({tag, "_illegal"}, 32'(ill_of(v.s4)), 32'(v.ill));
        check({tag, "_busy_cycles"}, 32'(bsy), 32'(v.lat - 1));
        held = res_of(v.s4);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done_of(v.s4)), 32'd0);
        check({tag, "_result_held"}, res_of(v.s4), held);
    endtask

    initial begin
        int seen;

        tbl[0]  = '{0, OP_SLL, AMT_CONST, 5'd0,  5'd0, 32'h0,
                    32'h0000_1234, 32'h1234_0000, 1'b0, 17};
        tbl[1]  = '{1, OP_SRA, AMT_SHAMT, 5'd0,  5'd7, 32'h0,
                    32'h8000_00F0, 32'hFF00_0001, 1'b0, 3};
        tbl[2]  = '{1, OP_ROR, AMT_REG,   5'd0,  5'd0, 32'h0000_0024,
                    32'h1234_5678, 32'h8123_4567, 1'b0, 2};
        tbl[3]  = '{1, OP_ROL, AMT_SE,    5'd0,  5'd0, 32'h0,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
        tbl[4]  = '{1, 3'b111, AMT_SE,    5'd5,  5'd0, 32'h0,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1};
        tbl[5]  = '{1, OP_SLL, AMT_SE,    5'd31, 5'd0, 32'h0,
                    32'h0000_0001, 32'h8000_0000, 1'b0, 9};
        tbl[6]  = '{1, OP_SRL, AMT_SE,    5'd8,  5'd0, 32'h0,
                    32'h8000_0000, 32'h0080_0000, 1'b0, 3};
        tbl[7]  = '{1, OP_ROL, AMT_SHAMT, 5'd0,  5'd5, 32'h0,
                    32'h8000_0001, 32'h0000_0030, 1'b0, 3};
        tbl[8]  = '{0, OP_SRA, AMT_SE,    5'd3,  5'd0, 32'h0,
                    32'h4000_0000, 32'h0800_0000, 1'b0, 4};
        tbl[9]  = '{0, OP_ROR, AMT_SE,    5'd1,  5'd0, 32'h0,
                    32'h0000_0001, 32'h8000_0000, 1'b0, 2};
        tbl[10] = '{1, 3'b101, AMT_REG,   5'd0,  5'd0, 32'h0000_0003,
                    32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1};

        drive(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 3'd0, 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", i1.result, 32'h0);
        check("rst_ready", 32'(i1.ready), 32'd1);
        check("rst_busy", 32'(i4.busy), 32'd0);
        check("rst_done", 32'(i4.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(i, tbl[i]);

        // reset asserted mid-SHIFT must abort without a done
        @(negedge clk);
        drive(1'b0, OP_SRL, AMT_SE, 5'd20, 5'd0, 32'h0, 32'hFFFF_0000, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, OP_SRL, AMT_SE, 5'd20, 5'd0, 32'h0, 32'hFFFF_0000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(i1.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(i1.busy), 32'd0);
        check("abort_ready", 32'(i1.ready), 32'd1);
        check("abort_result", i1.result, 32'h0);
        check("abort_done", 32'(i1.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (i1.done || i1.busy) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // back-to-back: start held through SHIFT, re-accepted from DONE
        @(negedge clk);
        drive(1'b0, OP_SLL, AMT_SE, 5'd2, 5'd0, 32'h0, 32'h0000_0001, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, OP_SRL, AMT_SE, 5'd1, 5'd0, 32'h0, 32'h0000_0004, 1'b1);
        check("b2b_busy_c1", 32'(i1.busy), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_busy_c2", 32'(i1.busy), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_done_c3", 32'(i1.done), 32'd1);
        check("b2b_result1", i1.result, 32'h0000_0004);
        @(posedge clk);
        #1;
        drive(1'b0, OP_SRL, AMT_SE, 5'd1, 5'd0, 32'h0, 32'h0000_0004, 1'b0);
        check("b2b_second_busy", 32'(i1.busy), 32'd1);
        check("b2b_second_nodone", 32'(i1.done), 32'd0);
        @(posedge clk);
        #1;
        check("b2b_second_done", 32'(i1.done), 32'd1);
        check("b2b_result2", i1.result, 32'h0000_0002);
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(i1.ready && !i1.done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
